spi_slave: RTL

Serial front end of the SPI-to-RAM subsystem. Deserialises MOSI frames into command words (two opcode bits plus a data byte) and presents them to the single-port RAM on `rx_data`/`rx_valid`. On a read-data command, it captures the RAM's `tx_data`/`tx_valid` response and shifts it out on MISO. SPI serial clock equals the system clock `clk`; MOSI/MISO change and are sampled on rising edges.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_slave.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI-to-RAM serial front end.
//   spi_state_e     : frame FSM state encoding
//   OP_*            : opcode values carried in command word bits [DATA_W+1:DATA_W]
//   DEFAULT_DATA_W  : default RAM data/address width
package spi_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_slave.sv
// spi_slave -- deserialises MOSI frames into DATA_W+2 bit command words and
// serialises the RAM read response back out on MISO. SCK is the system clock.
//   clk       : system / SPI clock, rising edge
//   rst_n     : asynchronous active-low reset
//   SS_n      : slave select, active-low; high on any edge aborts the frame
//   MOSI      : serial command input, MSB first
//   MISO      : registered serial read-data output, MSB first
//   rx_data   : assembled command word {opcode[1:0], payload[DATA_W-1:0]}
//   rx_valid  : one-cycle strobe qualifying rx_data
//   tx_data   : read byte returned by the RAM
//   tx_valid  : RAM response strobe (may stay high afterwards)
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int WORD_W   = DATA_W + 2;
  localparam int CNT_W    = $clog2(WORD_W);
  localparam int TX_CNT_W = $clog2(DATA_W + 1);

  spi_state_e state_reg, state_next;

  logic [CNT_W-1:0]    bit_cnt_reg;
  logic                rx_done_reg;
  logic [WORD_W-1:0]   rx_shift_reg;
  logic [WORD_W-1:0]   rx_data_reg;
  logic                rx_valid_reg;
  logic [DATA_W-1:0]   tx_shift_reg;
  logic [TX_CNT_W-1:0] tx_cnt_reg;
  logic                wait_tx_reg;
  logic                rd_addr_flag_reg;
  logic                miso_reg;
  logic                in_frame;
  logic                last_bit;

  assign MISO     = miso_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

  // Payload states share the same shifting behaviour.
  assign in_frame = (state_reg == WRITE) || (state_reg == READ_ADD) ||
                    (state_reg == READ_DATA);
  assign last_bit = (bit_cnt_reg == CNT_W'(WORD_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!SS_n) state_next = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)                  state_next = IDLE;
        else if (!MOSI)            state_next = WRITE;
        else if (rd_addr_flag_reg) state_next = READ_DATA;
        else                       state_next = READ_ADD;
      end
      default: begin
        if (SS_n) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg      <= '0;
      rx_done_reg      <= 1'b0;
      rx_shift_reg     <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      tx_shift_reg     <= '0;
      tx_cnt_reg       <= '0;
      wait_tx_reg      <= 1'b0;
      rd_addr_flag_reg <= 1'b0;
      miso_reg         <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (SS_n && state_reg != IDLE) begin
        // Abort: drop the partial frame entirely; rx_data keeps its last word.
        bit_cnt_reg  <= '0;
        rx_done_reg  <= 1'b0;
        rx_shift_reg <= '0;
        tx_shift_reg <= '0;
        tx_cnt_reg   <= '0;
        wait_tx_reg  <= 1'b0;
        miso_reg     <= 1'b0;
      end else if (state_reg == CHK_CMD) begin
        rx_shift_reg <= {{(WORD_W-1){1'b0}}, MOSI};
        bit_cnt_reg  <= CNT_W'(1);
      end else if (in_frame) begin
        if (!rx_done_reg) begin
          rx_shift_reg <= {rx_shift_reg[WORD_W-2:0], MOSI};
          if (last_bit) begin
            // Counter parks on the last index; rx_done blocks further shifting.
            rx_done_reg  <= 1'b1;
            rx_data_reg  <= {rx_shift_reg[WORD_W-2:0], MOSI};
            rx_valid_reg <= 1'b1;
            if (state_reg == READ_ADD)  rd_addr_flag_reg <= 1'b1;
            if (state_reg == READ_DATA) begin
              rd_addr_flag_reg <= 1'b0;
              wait_tx_reg      <= 1'b1;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
        end

        // Read response: capture once, MSB goes out immediately, the rest follow.
        if (wait_tx_reg && tx_valid) begin
          wait_tx_reg  <= 1'b0;
          miso_reg     <= tx_data[DATA_W-1];
          tx_shift_reg <= tx_data << 1;
          tx_cnt_reg   <= TX_CNT_W'(DATA_W - 1);
        end else if (tx_cnt_reg != '0) begin
          miso_reg     <= tx_shift_reg[DATA_W-1];
          tx_shift_reg <= tx_shift_reg << 1;
          tx_cnt_reg   <= tx_cnt_reg - TX_CNT_W'(1);
        end else begin
          miso_reg <= 1'b0;
        end
      end
    end
  end

endmodule
